// File: rtl/boa_csr_mtrap_if.sv
// CSR access bus and CSR exception/interrupt event bus shared by the Boa core and its CSR files.
interface boa_csr_bus;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned ADDRW = 12;

  logic             we;
  logic [ADDRW-1:0] addr;
  logic [XLEN-1:0]  wdata;
  logic             exists;
  logic             rdonly;
  logic [1:0]       priv;
  logic [XLEN-1:0]  rdata;

  modport CSR (input we, addr, wdata, output exists, rdonly, priv, rdata);
  modport CPU (output we, addr, wdata, input exists, rdonly, priv, rdata);
endinterface

interface boa_csr_ex_bus;
  localparam int unsigned XLEN = 32;

  logic            ex_trap;
  logic            ex_irq;
  logic [XLEN-2:0] ex_epc;
  logic [4:0]      ex_cause;
  logic [1:0]      ex_priv;
  logic [XLEN-3:0] ex_tvec;
  logic            ret;
  logic [1:0]      ret_priv;
  logic [XLEN-2:0] ret_epc;
  logic [XLEN-1:0] irq_ip;
  logic [XLEN-1:0] irq_mie;
  logic [XLEN-1:0] irq_sie;
  logic [XLEN-1:0] irq_mideleg;
  logic [XLEN-1:0] irq_medeleg;

  modport CSR (input ex_trap, ex_irq, ex_epc, ex_cause, ex_priv, ret, ret_priv, irq_ip,
               output ex_tvec, ret_epc, irq_mie, irq_sie, irq_mideleg, irq_medeleg);
  modport CPU (output ex_trap, ex_irq, ex_epc, ex_cause, ex_priv, ret, ret_priv, irq_ip,
               input ex_tvec, ret_epc, irq_mie, irq_sie, irq_mideleg, irq_medeleg);
endinterface

// File: rtl/boa_csr_mtrap.sv
// Machine-mode trap CSR file (mstatus/mie/mtvec/mscratch/mepc/mcause plus read-only mip/misa/mhartid).
// Optional vectored interrupt dispatch through mtvec.MODE is enabled by defining BOA_CSR_VECTORED_EN.
module boa_csr_mtrap #(
  parameter logic [31:0] MISA     = 32'h4000_0100,
  parameter logic [31:0] HARTID   = 32'h0000_0000,
  parameter logic [31:0] MIE_MASK = 32'hFFFF_0888
) (
  input logic        clk,
  input logic        rst_n,
  boa_csr_bus.CSR    csr,
  boa_csr_ex_bus.CSR ex
);
  localparam int unsigned XLEN = 32;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-3:0] r_mtvec_base;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-2:0] r_mepc;
  logic            r_mcause_int;
  logic [4:0]      r_mcause_code;

  logic            w_mtvec_mode;
  logic            w_trap;
  logic            w_wr;
  logic            w_exists;
  logic            w_rdonly;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-3:0] w_tvec;
  logic            w_unused;

  assign w_trap = ex.ex_trap | ex.ex_irq;
  assign w_wr   = csr.we & w_exists & ~w_rdonly & ~w_trap;

  // Combinational address decode and read mux
  always_comb begin
    w_exists = 1'b1;
    w_rdonly = 1'b0;
    w_rdata  = '0;
    case (csr.addr)
      A_MSTATUS:  w_rdata = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
      A_MISA:     begin w_rdata = MISA; w_rdonly = 1'b1; end
      A_MIE:      w_rdata = r_mie;
      A_MTVEC:    w_rdata = {r_mtvec_base, 1'b0, w_mtvec_mode};
      A_MSCRATCH: w_rdata = r_mscratch;
      A_MEPC:     w_rdata = {r_mepc, 1'b0};
      A_MCAUSE:   w_rdata = {r_mcause_int, 26'b0, r_mcause_code};
      A_MIP:      begin w_rdata = ex.irq_ip; w_rdonly = 1'b1; end
      A_MHARTID:  begin w_rdata = HARTID; w_rdonly = 1'b1; end
      default:    w_exists = 1'b0;
    endcase
  end

  assign csr.exists = w_exists;
  assign csr.rdonly = w_rdonly;
  assign csr.priv   = 2'b11;
  assign csr.rdata  = w_rdata;

  // Trap entry beats return, which beats CSR writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec_base   <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause_int   <= 1'b0;
      r_mcause_code  <= '0;
    end else if (w_trap) begin
      r_mepc         <= ex.ex_epc;
      r_mcause_int   <= ex.ex_irq;
      r_mcause_code  <= ex.ex_cause;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else begin
      if (ex.ret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wr && csr.addr == A_MSTATUS) begin
        r_mstatus_mie  <= csr.wdata[3];
        r_mstatus_mpie <= csr.wdata[7];
      end
      if (w_wr) begin
        case (csr.addr)
          A_MIE:      r_mie         <= csr.wdata & MIE_MASK;
          A_MTVEC:    r_mtvec_base  <= csr.wdata[XLEN-1:2];
          A_MSCRATCH: r_mscratch    <= csr.wdata;
          A_MEPC:     r_mepc        <= csr.wdata[XLEN-1:1];
          A_MCAUSE: begin
            r_mcause_int  <= csr.wdata[XLEN-1];
            r_mcause_code <= csr.wdata[4:0];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BOA_CSR_VECTORED_EN
  logic r_mtvec_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtvec_mode <= 1'b0;
    end else if (w_wr && csr.addr == A_MTVEC) begin
      r_mtvec_mode <= csr.wdata[0];
    end
  end

  assign w_mtvec_mode = r_mtvec_mode;
  // Only interrupts are vectored; the sum wraps within the 30-bit BASE field
  assign w_tvec = (r_mtvec_mode && ex.ex_irq) ? r_mtvec_base + 30'(ex.ex_cause) : r_mtvec_base;
`else
  assign w_mtvec_mode = 1'b0;
  assign w_tvec       = r_mtvec_base;
`endif

  assign ex.ex_tvec     = w_tvec;
  assign ex.ret_epc     = r_mepc;
  assign ex.irq_mie     = r_mie;
  assign ex.irq_sie     = ex.irq_ip & r_mie & {XLEN{r_mstatus_mie}};
  assign ex.irq_mideleg = '0;
  assign ex.irq_medeleg = '0;

  // Privilege inputs carry no information in an M-mode-only core
  assign w_unused = ^{ex.ex_priv, ex.ret_priv};
endmodule

// File: tb/tb_boa_csr_mtrap.sv
// Directed, table-driven bench for boa_csr_mtrap: CSR read/write vectors plus trap, return,
// vectored-interrupt and masking sequences.
module tb_boa_csr_mtrap;
  localparam logic VEC =
`ifdef BOA_CSR_VECTORED_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  boa_csr_bus    csr_if ();
  boa_csr_ex_bus ex_if ();

  boa_csr_mtrap dut (
    .clk   (clk),
    .rst_n (rst_n),
    .csr   (csr_if),
    .ex    (ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_exists;
    logic        exp_rdonly;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 32'h%08h expected 32'h%08h", name, act, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_if.we    = 1'b1;
    csr_if.addr  = a;
    csr_if.wdata = d;
    @(negedge clk);
    csr_if.we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_if.addr = a;
    #1;
    chk(name, csr_if.rdata, exp);
  endtask

  task automatic pulse(input logic trap, input logic irq, input logic [30:0] epc,
                       input logic [4:0] cause, input logic [29:0] exp_tvec, input string name);
    @(negedge clk);
    ex_if.ex_trap  = trap;
    ex_if.ex_irq   = irq;
    ex_if.ex_epc   = epc;
    ex_if.ex_cause = cause;
    #1;
    chk(name, 32'(ex_if.ex_tvec), 32'(exp_tvec));
    @(negedge clk);
    ex_if.ex_trap = 1'b0;
    ex_if.ex_irq  = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    csr_if.we    = 1'b0;
    csr_if.addr  = 12'h300;
    csr_if.wdata = '0;
    ex_if.ex_trap  = 1'b0;
    ex_if.ex_irq   = 1'b0;
    ex_if.ex_epc   = '0;
    ex_if.ex_cause = '0;
    ex_if.ex_priv  = 2'b11;
    ex_if.ret      = 1'b0;
    ex_if.ret_priv = 2'b11;
    ex_if.irq_ip   = '0;

    vecs.push_back('{1'b0, 12'h300, 32'h0,         32'h0000_1800, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h301, 32'h0,         32'h4000_0100, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 12'h304, 32'h0,         32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h305, 32'h0,         32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h340, 32'h0,         32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h341, 32'h0,         32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h342, 32'h0,         32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h344, 32'h0,         32'h0,         1'b1, 1'b1});
    vecs.push_back('{1'b0, 12'hF14, 32'h0,         32'h0,         1'b1, 1'b1});
    vecs.push_back('{1'b0, 12'h7C0, 32'h0,         32'h0,         1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h7C0, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h304, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h304, 32'h0,         32'hFFFF_0888, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h341, 32'h1234_5679, 32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h341, 32'h0,         32'h1234_5678, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h344, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1});
    vecs.push_back('{1'b0, 12'h344, 32'h0,         32'h0,         1'b1, 1'b1});
    vecs.push_back('{1'b1, 12'h301, 32'h0,         32'h4000_0100, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 12'h301, 32'h0,         32'h4000_0100, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 12'h340, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h340, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h342, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h342, 32'h0,         32'h8000_001F, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h300, 32'h0,         32'h0000_1888, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h300, 32'h0,         32'h0000_1888, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h300, 32'h0,         32'h0000_1800, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h305, 32'h0000_0203, 32'h0,         1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h305, 32'h0, (VEC ? 32'h0000_0201 : 32'h0000_0200), 1'b1, 1'b0});

    // Outputs while held in reset
    #12;
    chk("rst_ret_epc", 32'(ex_if.ret_epc), 32'h0);
    chk("rst_ex_tvec", 32'(ex_if.ex_tvec), 32'h0);
    chk("rst_irq_mie", ex_if.irq_mie, 32'h0);
    chk("rst_irq_sie", ex_if.irq_sie, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drive at negedge, check decode before the write edge
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      csr_if.we    = vecs[i].we;
      csr_if.addr  = vecs[i].addr;
      csr_if.wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdata", i), csr_if.rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_exists", i), 32'(csr_if.exists), 32'(vecs[i].exp_exists));
      chk($sformatf("vec%0d_rdonly", i), 32'(csr_if.rdonly), 32'(vecs[i].exp_rdonly));
      chk($sformatf("vec%0d_priv", i), 32'(csr_if.priv), 32'h3);
    end
    @(negedge clk);
    csr_if.we = 1'b0;
    chk("deleg_m", ex_if.irq_mideleg, 32'h0);
    chk("deleg_e", ex_if.irq_medeleg, 32'h0);

    // Synchronous trap with a simultaneous mscratch write and ret, both discarded
    wr(12'h300, 32'h0000_0008);
    wr(12'h305, 32'h0000_0100);
    @(negedge clk);
    ex_if.ex_trap  = 1'b1;
    ex_if.ex_epc   = 31'h4000_0020;
    ex_if.ex_cause = 5'd2;
    ex_if.ret      = 1'b1;
    csr_if.we      = 1'b1;
    csr_if.addr    = 12'h340;
    csr_if.wdata   = 32'h1111_1111;
    #1;
    chk("trap_tvec", 32'(ex_if.ex_tvec), 32'h0000_0040);
    @(negedge clk);
    ex_if.ex_trap = 1'b0;
    ex_if.ret     = 1'b0;
    csr_if.we     = 1'b0;
    rd("trap_mepc", 12'h341, 32'h8000_0040);
    rd("trap_mcause", 12'h342, 32'h0000_0002);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    rd("trap_mscratch", 12'h340, 32'hDEAD_BEEF);
    chk("trap_ret_epc", 32'(ex_if.ret_epc), 32'h4000_0020);

    @(negedge clk);
    ex_if.ret = 1'b1;
    @(negedge clk);
    ex_if.ret = 1'b0;
    rd("ret_mstatus", 12'h300, 32'h0000_1888);
    chk("ret_ret_epc", 32'(ex_if.ret_epc), 32'h4000_0020);

    // Vectored interrupt versus direct mode
    wr(12'h305, 32'h0000_0201);
    rd("vec_mtvec", 12'h305, VEC ? 32'h0000_0201 : 32'h0000_0200);
    pulse(1'b0, 1'b1, 31'h0000_0100, 5'd7, VEC ? 30'h87 : 30'h80, "irq_tvec");
    rd("irq_mcause", 12'h342, 32'h8000_0007);
    rd("irq_mepc", 12'h341, 32'h0000_0200);
    pulse(1'b1, 1'b0, 31'h0000_0100, 5'd3, 30'h80, "sync_tvec");
    rd("sync_mcause", 12'h342, 32'h0000_0003);
    pulse(1'b1, 1'b1, 31'h0000_0100, 5'd4, VEC ? 30'h84 : 30'h80, "both_tvec");
    rd("both_mcause", 12'h342, 32'h8000_0004);
    wr(12'h305, 32'hFFFF_FFFD);
    pulse(1'b0, 1'b1, 31'h0000_0100, 5'd2, VEC ? 30'h0000_0001 : 30'h3FFF_FFFF, "wrap_tvec");

    // Interrupt masking and asynchronous reset
    ex_if.irq_ip = 32'h0000_0880;
    wr(12'h304, 32'h0000_0080);
    wr(12'h300, 32'h0000_0000);
    chk("mask_mie0_sie", ex_if.irq_sie, 32'h0);
    chk("mask_irq_mie", ex_if.irq_mie, 32'h0000_0080);
    rd("mask_mip", 12'h344, 32'h0000_0880);
    wr(12'h300, 32'h0000_0008);
    chk("mask_mie1_sie", ex_if.irq_sie, 32'h0000_0080);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irq_sie", ex_if.irq_sie, 32'h0);
    chk("arst_irq_mie", ex_if.irq_mie, 32'h0);
    chk("arst_ex_tvec", 32'(ex_if.ex_tvec), 32'h0);
    chk("arst_ret_epc", 32'(ex_if.ret_epc), 32'h0);
    rd("arst_mstatus", 12'h300, 32'h0000_1800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
